// File: rtl/bitnet_mvm_engine.sv
// bitnet_mvm_engine: ternary matrix-vector engine with serial scaled output.
// Define BITNET_MVM_SAT_EN to saturate results instead of wrapping them.
module bitnet_mvm_engine #(
  parameter int ACT_W   = 8,
  parameter int LANES   = 32,
  parameter int NUM_OUT = 32,
  parameter int TILES   = 4,
  parameter int ACC_W   = 32,
  parameter int SCALE_W = 16,
  parameter int SHIFT   = 8,
  parameter int OUT_W   = 32,
  localparam int CW = (NUM_OUT > 1) ? $clog2(NUM_OUT) : 1
) (
  input  logic                       clk,
  input  logic                       rst_n_i,
  input  logic                       valid_in_i_act,
  output logic                       ready_in_o_act,
  input  logic [LANES*ACT_W-1:0]     data_i_act,
  input  logic                       valid_in_i_wm,
  output logic                       ready_in_o_wm,
  input  logic [2*LANES-1:0]         data_i_wm,
  input  logic                       valid_in_i_ws,
  output logic                       ready_in_o_ws,
  input  logic [NUM_OUT*SCALE_W-1:0] data_i_ws,
  output logic                       valid_out_o,
  input  logic                       ready_out_i,
  output logic [OUT_W-1:0]           result_o,
  output logic [CW-1:0]              ch_idx_o,
  output logic                       last_o,
  output logic                       busy_o
);

  localparam int TW = (TILES > 1) ? $clog2(TILES) : 1;
  localparam int PW = ACC_W + SCALE_W;
  localparam logic [CW-1:0] LAST_CH = CW'(NUM_OUT - 1);
  localparam logic [TW-1:0] LAST_TILE = TW'(TILES - 1);

  typedef enum logic [1:0] {
    S_ACT,
    S_WM,
    S_WS,
    S_OUT
  } state_t;

  state_t state_q, state_d;

  logic [TW-1:0]             tile_q;
  logic [CW-1:0]             row_q;
  logic [CW-1:0]             ch_q;
  logic [LANES*ACT_W-1:0]    act_q;
  logic signed [ACC_W-1:0]   acc_q [NUM_OUT];
  logic signed [SCALE_W-1:0] scale_q [NUM_OUT];

  logic act_fire, wm_fire, ws_fire, out_fire;
  logic signed [ACC_W-1:0] dot;
  logic signed [ACC_W-1:0] lane_v;
  logic signed [PW-1:0]    prod;
  logic signed [PW-1:0]    shifted;

  assign act_fire = ready_in_o_act & valid_in_i_act;
  assign wm_fire  = ready_in_o_wm & valid_in_i_wm;
  assign ws_fire  = ready_in_o_ws & valid_in_i_ws;
  assign out_fire = valid_out_o & ready_out_i;

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n_i) state_q <= S_ACT;
    else          state_q <= state_d;
  end

  // Next state and per-state handshake strobes
  always_comb begin
    state_d        = state_q;
    ready_in_o_act = 1'b0;
    ready_in_o_wm  = 1'b0;
    ready_in_o_ws  = 1'b0;
    valid_out_o    = 1'b0;
    case (state_q)
      S_ACT: begin
        ready_in_o_act = 1'b1;
        if (valid_in_i_act) state_d = S_WM;
      end
      S_WM: begin
        ready_in_o_wm = 1'b1;
        if (valid_in_i_wm && row_q == LAST_CH)
          state_d = (tile_q == LAST_TILE) ? S_WS : S_ACT;
      end
      S_WS: begin
        ready_in_o_ws = 1'b1;
        if (valid_in_i_ws) state_d = S_OUT;
      end
      S_OUT: begin
        valid_out_o = 1'b1;
        if (ready_out_i && ch_q == LAST_CH) state_d = S_ACT;
      end
      default: state_d = S_ACT;
    endcase
  end

  // Ternary dot product of the latched act beat with the offered row
  always_comb begin
    dot    = '0;
    lane_v = '0;
    for (int i = 0; i < LANES; i++) begin
      lane_v = ACC_W'($signed(act_q[i*ACT_W +: ACT_W]));
      case (data_i_wm[2*i +: 2])
        2'b01:   dot = dot + lane_v;
        2'b11:   dot = dot - lane_v;
        default: ;
      endcase
    end
  end

  // Counters, act/scale latches and per-channel accumulators
  always_ff @(posedge clk) begin
    if (!rst_n_i) begin
      tile_q <= '0;
      row_q  <= '0;
      ch_q   <= '0;
      act_q  <= '0;
      for (int c = 0; c < NUM_OUT; c++) begin
        acc_q[c]   <= '0;
        scale_q[c] <= '0;
      end
    end else begin
      if (act_fire) begin
        act_q <= data_i_act;
        row_q <= '0;
      end
      if (wm_fire) begin
        acc_q[row_q] <= acc_q[row_q] + dot;
        if (row_q == LAST_CH) begin
          row_q <= '0;
          if (tile_q != LAST_TILE) tile_q <= tile_q + TW'(1);
        end else begin
          row_q <= row_q + CW'(1);
        end
      end
      if (ws_fire) begin
        for (int c = 0; c < NUM_OUT; c++)
          scale_q[c] <= data_i_ws[c*SCALE_W +: SCALE_W];
        ch_q <= '0;
      end
      if (out_fire) begin
        if (ch_q == LAST_CH) begin
          ch_q   <= '0;
          tile_q <= '0;
          for (int c = 0; c < NUM_OUT; c++) acc_q[c] <= '0;
        end else begin
          ch_q <= ch_q + CW'(1);
        end
      end
    end
  end

  // Full-width scaled product of the current channel, then shift
  always_comb begin
    prod    = PW'(acc_q[ch_q]) * PW'(scale_q[ch_q]);
    shifted = prod >>> SHIFT;
  end

  generate
    if (OUT_W < PW) begin : g_narrow
`ifdef BITNET_MVM_SAT_EN
      logic [PW-OUT_W:0] top;
      assign top = shifted[PW-1:OUT_W-1];
      // Clamp when the dropped bits are not a pure sign extension
      always_comb begin
        if (&top || ~|top)
          result_o = shifted[OUT_W-1:0];
        else if (top[PW-OUT_W])
          result_o = {1'b1, {(OUT_W-1){1'b0}}};
        else
          result_o = {1'b0, {(OUT_W-1){1'b1}}};
      end
`else
      logic unused_hi;
      assign unused_hi = ^shifted[PW-1:OUT_W];
      assign result_o  = shifted[OUT_W-1:0];
`endif
    end else begin : g_wide
      assign result_o = OUT_W'(shifted);
    end
  endgenerate

  assign ch_idx_o = ch_q;
  assign last_o   = (state_q == S_OUT) && (ch_q == LAST_CH);
  assign busy_o   = !((state_q == S_ACT) && (tile_q == '0));

endmodule

// File: tb/tb_bitnet_mvm_engine.sv
// tb_bitnet_mvm_engine: table + scoreboard bench for bitnet_mvm_engine.
// Runs OUT_W=32 and OUT_W=16 copies in lockstep; honours BITNET_MVM_SAT_EN.
module tb_bitnet_mvm_engine;
  localparam int ACT_W = 8, LANES = 32, NUM_OUT = 32, TILES = 4;
  localparam int SCALE_W = 16, TMO = 300;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic                       act_v, wm_v, ws_v, rdy_out;
  logic [LANES*ACT_W-1:0]     act_d;
  logic [2*LANES-1:0]         wm_d;
  logic [NUM_OUT*SCALE_W-1:0] ws_d;
  logic rdy_act, rdy_wm, rdy_ws, vout, last, busy;
  logic [31:0] res;
  logic [4:0]  ch;
  logic r16_act, r16_wm, r16_ws, v16, last16, busy16;
  logic [15:0] res16;
  logic [4:0]  ch16;

  bitnet_mvm_engine #(.OUT_W(32)) dut (
    .clk(clk), .rst_n_i(rst_n),
    .valid_in_i_act(act_v), .ready_in_o_act(rdy_act), .data_i_act(act_d),
    .valid_in_i_wm(wm_v), .ready_in_o_wm(rdy_wm), .data_i_wm(wm_d),
    .valid_in_i_ws(ws_v), .ready_in_o_ws(rdy_ws), .data_i_ws(ws_d),
    .valid_out_o(vout), .ready_out_i(rdy_out), .result_o(res),
    .ch_idx_o(ch), .last_o(last), .busy_o(busy));

  bitnet_mvm_engine #(.OUT_W(16)) dut16 (
    .clk(clk), .rst_n_i(rst_n),
    .valid_in_i_act(act_v), .ready_in_o_act(r16_act), .data_i_act(act_d),
    .valid_in_i_wm(wm_v), .ready_in_o_wm(r16_wm), .data_i_wm(wm_d),
    .valid_in_i_ws(ws_v), .ready_in_o_ws(r16_ws), .data_i_ws(ws_d),
    .valid_out_o(v16), .ready_out_i(rdy_out), .result_o(res16),
    .ch_idx_o(ch16), .last_o(last16), .busy_o(busy16));

  typedef struct {
    logic [7:0]  act;
    logic [1:0]  c_lo;
    logic [1:0]  c_hi;
    logic [15:0] scale;
    int          r32;
    int          r16;
  } vec_t;

  typedef struct {
    int r32;
    int r16;
    int ch;
    bit last;
  } exp_t;

  vec_t tbl[7];
  exp_t q[$];
  exp_t m_e;
  int checks = 0, errors = 0, xfers = 0, onehot_err = 0;

  logic [LANES*ACT_W-1:0]     j_act [TILES];
  logic [2*LANES-1:0]         j_wm [TILES][NUM_OUT];
  logic [NUM_OUT*SCALE_W-1:0] j_ws;

  task automatic chk(input string nm, input logic signed [63:0] a,
                     input logic signed [63:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, a, e);
    end
  endtask

  // Output monitor: pops the scoreboard on each output transfer
  always @(negedge clk) begin
    if (rst_n && !$onehot({rdy_act, rdy_wm, rdy_ws, vout})) onehot_err++;
    if (rst_n && vout && rdy_out) begin
      xfers++;
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL spurious_out: ch %0d with empty scoreboard", ch);
      end else begin
        m_e = q.pop_front();
        chk("res32", $signed(res), m_e.r32);
        chk("res16", $signed(res16), m_e.r16);
        chk("ch_idx", ch, m_e.ch);
        chk("last", last, m_e.last);
      end
    end
  end

  task automatic fill_uniform(input vec_t v);
    for (int t = 0; t < TILES; t++) begin
      for (int i = 0; i < LANES; i++) j_act[t][i*ACT_W +: ACT_W] = v.act;
      for (int r = 0; r < NUM_OUT; r++)
        for (int i = 0; i < LANES; i++)
          j_wm[t][r][2*i +: 2] = (i < 16) ? v.c_lo : v.c_hi;
    end
    for (int c = 0; c < NUM_OUT; c++) j_ws[c*SCALE_W +: SCALE_W] = v.scale;
  endtask

  task automatic push_uniform(input vec_t v);
    exp_t e;
    for (int c = 0; c < NUM_OUT; c++) begin
      e.r32 = v.r32;
      e.r16 = v.r16;
      e.ch = c;
      e.last = (c == NUM_OUT - 1);
      q.push_back(e);
    end
  endtask

  task automatic fill_random();
    for (int t = 0; t < TILES; t++) begin
      for (int i = 0; i < LANES; i++)
        j_act[t][i*ACT_W +: ACT_W] = 8'($urandom);
      for (int r = 0; r < NUM_OUT; r++) j_wm[t][r] = {$urandom, $urandom};
    end
    for (int c = 0; c < NUM_OUT; c++)
      j_ws[c*SCALE_W +: SCALE_W] = 16'($urandom);
  endtask

  task automatic push_model();
    exp_t e;
    logic signed [31:0] acc;
    logic signed [7:0]  a;
    logic signed [15:0] s;
    logic [1:0]         code;
    longint             p, sh;
    for (int c = 0; c < NUM_OUT; c++) begin
      acc = 0;
      for (int t = 0; t < TILES; t++)
        for (int i = 0; i < LANES; i++) begin
          a = j_act[t][i*ACT_W +: ACT_W];
          code = j_wm[t][c][2*i +: 2];
          if (code == 2'b01) acc = acc + 32'(a);
          else if (code == 2'b11) acc = acc - 32'(a);
        end
      s = j_ws[c*SCALE_W +: SCALE_W];
      p = longint'(acc) * longint'(s);
      sh = p >>> 8;
      e.r32 = int'(sh);
`ifdef BITNET_MVM_SAT_EN
      if (sh > 32767) e.r16 = 32767;
      else if (sh < -32768) e.r16 = -32768;
      else e.r16 = int'(sh);
`else
      e.r16 = int'(shortint'(sh));
`endif
      e.ch = c;
      e.last = (c == NUM_OUT - 1);
      q.push_back(e);
    end
  endtask

  task automatic send_act(input logic [LANES*ACT_W-1:0] d);
    int n = 0;
    act_d = d;
    act_v = 1'b1;
    @(negedge clk);
    while (!rdy_act && n < TMO) begin @(negedge clk); n++; end
    chk("act_ready", rdy_act, 1);
    @(posedge clk); #1;
    act_v = 1'b0;
  endtask

  task automatic send_wm(input logic [2*LANES-1:0] d);
    int n = 0;
    wm_d = d;
    wm_v = 1'b1;
    @(negedge clk);
    while (!rdy_wm && n < TMO) begin @(negedge clk); n++; end
    if (!rdy_wm) chk("wm_ready", rdy_wm, 1);
    @(posedge clk); #1;
    wm_v = 1'b0;
  endtask

  task automatic send_ws(input logic [NUM_OUT*SCALE_W-1:0] d);
    int n = 0;
    ws_d = d;
    ws_v = 1'b1;
    @(negedge clk);
    while (!rdy_ws && n < TMO) begin @(negedge clk); n++; end
    chk("ws_ready", rdy_ws, 1);
    @(posedge clk); #1;
    ws_v = 1'b0;
  endtask

  // Drives one job; optional off-state valids; optional reset at (ab_t, ab_r)
  task automatic drive_job(input bit ordering, input int ab_t, input int ab_r);
    for (int t = 0; t < TILES; t++) begin
      if (ordering) begin
        wm_v = 1'b1;
        ws_v = 1'b1;
        wm_d = {$urandom, $urandom};
        ws_d = {16{$urandom}};
        repeat (3) begin
          @(negedge clk);
          chk("ord_wm_rdy", rdy_wm, 0);
          chk("ord_ws_rdy", rdy_ws, 0);
        end
        @(posedge clk); #1;
        wm_v = 1'b0;
        ws_v = 1'b0;
      end
      send_act(j_act[t]);
      if (t == 0) begin
        @(negedge clk);
        chk("busy_mid", busy, 1);
        @(posedge clk); #1;
      end
      for (int r = 0; r < NUM_OUT; r++) begin
        if (t == ab_t && r == ab_r) begin
          act_v = 1'b0;
          rst_n = 1'b0;
          @(posedge clk); #1;
          rst_n = 1'b1;
          @(negedge clk);
          chk("rst_mid_act_rdy", rdy_act, 1);
          chk("rst_mid_busy", busy, 0);
          chk("rst_mid_wm_rdy", rdy_wm, 0);
          chk("rst_mid_vout", vout, 0);
          @(posedge clk); #1;
          return;
        end
        if (ordering) begin
          act_v = (r != NUM_OUT - 1);
          act_d = ~j_act[t];
        end
        send_wm(j_wm[t][r]);
      end
      act_v = 1'b0;
    end
    send_ws(j_ws);
  endtask

  task automatic wait_drain();
    int n = 0;
    @(negedge clk);
    while ((q.size() != 0 || vout) && n < TMO) begin @(negedge clk); n++; end
    chk("drain_left", q.size(), 0);
    chk("b2b_act_rdy", rdy_act, 1);
    chk("idle_busy", busy, 0);
    @(posedge clk); #1;
  endtask

  initial begin
    int n;
    tbl[0] = '{8'd1,   2'b01, 2'b01, 16'd256,  128,      128};
    tbl[1] = '{8'd3,   2'b11, 2'b10, 16'd256,  -192,     -192};
`ifdef BITNET_MVM_SAT_EN
    tbl[2] = '{8'h80,  2'b01, 2'b01, 16'h7FFF, -2097088, -32768};
`else
    tbl[2] = '{8'h80,  2'b01, 2'b01, 16'h7FFF, -2097088, 64};
`endif
    tbl[3] = '{8'd5,   2'b01, 2'b11, 16'd1234, 0,        0};
    tbl[4] = '{8'd127, 2'b01, 2'b00, 16'hFF00, -8128,    -8128};
    tbl[5] = '{8'hFF,  2'b11, 2'b11, 16'd3,    1,        1};
    tbl[6] = '{8'd1,   2'b11, 2'b11, 16'd3,    -2,       -2};

    act_v = 0; wm_v = 0; ws_v = 0; rdy_out = 1;
    act_d = '0; wm_d = '0; ws_d = '0;
    rst_n = 0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1;
    @(negedge clk);
    chk("rst_act_rdy", rdy_act, 1);
    chk("rst_wm_rdy", rdy_wm, 0);
    chk("rst_ws_rdy", rdy_ws, 0);
    chk("rst_vout", vout, 0);
    chk("rst_result", res, 0);
    chk("rst_ch", ch, 0);
    chk("rst_last", last, 0);
    chk("rst_busy", busy, 0);
    @(posedge clk); #1;

    for (int k = 0; k < 7; k++) begin
      fill_uniform(tbl[k]);
      push_uniform(tbl[k]);
      drive_job(0, -1, -1);
      wait_drain();
    end

    // Backpressure while channel 3 is presented
    fill_uniform(tbl[0]);
    push_uniform(tbl[0]);
    xfers = 0;
    drive_job(0, -1, -1);
    n = 0;
    do begin @(negedge clk); n++; end while (!(vout && ch == 2) && n < TMO);
    chk("bp_reach_ch2", ch, 2);
    @(posedge clk); #1;
    rdy_out = 0;
    repeat (5) begin
      @(negedge clk);
      chk("bp_vout", vout, 1);
      chk("bp_ch", ch, 3);
      chk("bp_result", $signed(res), 128);
    end
    @(posedge clk); #1;
    rdy_out = 1;
    wait_drain();
    chk("bp_xfers", xfers, 32);

    // Valids asserted on ports that are not ready
    fill_uniform(tbl[0]);
    push_uniform(tbl[0]);
    drive_job(1, -1, -1);
    wait_drain();

    // Reset at tile 2 row 10, then a clean basic job
    fill_uniform(tbl[0]);
    xfers = 0;
    drive_job(0, 2, 10);
    push_uniform(tbl[0]);
    drive_job(0, -1, -1);
    wait_drain();
    chk("rst_job_xfers", xfers, 32);

    // Per-channel random data against the reference model
    for (int k = 0; k < 2; k++) begin
      fill_random();
      push_model();
      drive_job(0, -1, -1);
      wait_drain();
    end

    chk("onehot_ready", onehot_err, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/bitnet_mvm_engine.md
Name: bitnet_mvm_engine

Overview:
- Parametrised ternary matrix-vector engine for BitNet layers: OUT[ch] = ((Σ_k act[k]·w[ch][k]) · scale[ch]) >>> SHIFT, with signed activations and ternary weights.
- Takes activation, weight-matrix and weight-scale streams over three valid/ready ports, then accumulates over TILES activation beats.
- Emits NUM_OUT results serially over a valid/ready output port, replacing the fixed 32-wide parallel result bus.

Parameters:
- ACT_W, 8, signed activation element width
- LANES, 32, activation elements per act beat and weights per wm beat
- NUM_OUT, 32, output channels
- TILES, 4, act beats accumulated per job (K = LANES·TILES)
- ACC_W, 32, signed accumulator width; must be ≥ ACT_W+clog2(LANES·TILES)+1
- SCALE_W, 16, signed per-channel scale width
- SHIFT, 8, arithmetic right shift applied after scaling (Q.8 scale, 256 = 1.0)
- OUT_W, 32, signed result width

Ports:
- clk  in  1  clock
- rst_n_i  in  1  reset; one clock, synchronous, active-low
- valid_in_i_act  in  1  act beat valid
- ready_in_o_act  out  1  act beat ready
- data_i_act  in  LANES*ACT_W  act elements; lane i at bits [i*ACT_W +: ACT_W]
- valid_in_i_wm  in  1  weight row valid
- ready_in_o_wm  out  1  weight row ready
- data_i_wm  in  2*LANES  ternary row for one channel; lane i at bits [2i +: 2]
- valid_in_i_ws  in  1  scale beat valid
- ready_in_o_ws  out  1  scale beat ready
- data_i_ws  in  NUM_OUT*SCALE_W  scales; channel c at bits [c*SCALE_W +: SCALE_W]
- valid_out_o  out  1  result valid
- ready_out_i  in  1  downstream ready
- result_o  out  OUT_W  scaled result
- ch_idx_o  out  clog2(NUM_OUT)  channel index of result_o
- last_o  out  1  high with channel NUM_OUT-1
- busy_o  out  1  high in any state except S_ACT with tile 0

Behaviour:
- Handshake on each port: a transfer occurs when valid & ready are both high at a clk edge. Ready is a function of state only and never depends on valid.
- Ternary weight code: 2'b01 = +1, 2'b11 = -1, 2'b00 and 2'b10 = 0.
- FSM states:
  - S_ACT: ready_in_o_act = 1. On transfer, latch act beat → S_WM, row counter = 0.
  - S_WM: ready_in_o_wm = 1. Each transfer updates acc[row] += dot(act, row). Row increments.
    - After row NUM_OUT-1: if tile < TILES-1, tile++ and go to S_ACT; else go to S_WS.
  - S_WS: ready_in_o_ws = 1. On transfer, latch all scales → S_OUT, ch = 0.
  - S_OUT: valid_out_o = 1. On transfer, ch++.
    - On the last transfer: clear every acc and tile → S_ACT.
- Only one ready is high in any cycle. Beats offered on a non-ready port are held off, never dropped.
- dot(): sum of ±act or 0 per lane, sign-extended to ACC_W. The accumulator wraps modulo 2^ACC_W.
- Accumulator update latency: the row accepted at edge t is visible in acc at edge t. One wm beat per cycle is sustained; no bubbles are needed.
- result_o is derived from registered state only (acc[ch], scale[ch]):
  - p = acc·scale at full ACC_W+SCALE_W width, then p >>> SHIFT (arithmetic), then reduced to OUT_W as set by the optional feature.
- While valid_out_o = 1 and ready_out_i = 0: result_o, ch_idx_o and last_o hold stable.
- Reset values: state S_ACT, tile 0, row 0, ch 0, all acc 0, all scales 0. Outputs: ready_in_o_act = 1, ready_in_o_wm = ready_in_o_ws = 0, valid_out_o = 0, result_o = 0, ch_idx_o = 0, last_o = 0, busy_o = 0.
- Reset mid-job, in any state: the next cycle presents the reset values. The partial job is discarded.
- Back-to-back jobs: the act beat of the next job can be accepted in the cycle after the final output transfer.

Optional Feature:
- BITNET_MVM_SAT_EN defined: the shifted product saturates to [-2^(OUT_W-1), 2^(OUT_W-1)-1].
- Not defined: the shifted product is truncated to its low OUT_W bits (two's-complement wrap).

Test Plan:
- Basic job, defaults. Act all 8'sd1, all rows 2'b01, scales all 256, ready_out_i = 1.
  - Expect 32 results of 128, ch_idx 0..31, last_o only on ch 31.
- Mixed codes. Lanes 0-15 coded 2'b11, lanes 16-31 coded 2'b10, act 8'sd3, scale 256.
  - Expect every result = -192.
- OUT_W = 16. Act all 8'h80, rows 2'b01, scale 16'h7FFF; shifted product = -2097088.
  - With BITNET_MVM_SAT_EN: result_o = -32768.
  - Without it: result_o = 64.
- Backpressure. Drop ready_out_i for 5 cycles while ch_idx_o = 3.
  - valid_out_o stays 1; result_o and ch_idx_o are unchanged.
  - No result is lost or duplicated; exactly 32 transfers occur.
- Port ordering. Assert wm/ws valid during S_ACT, and act valid during S_WM.
  - No out-of-state transfer occurs; results are identical to the basic job.
- Reset mid-op. Pull rst_n_i low for 1 cycle during tile 2, row 10.
  - Next cycle: ready_in_o_act = 1, busy_o = 0.
  - A fresh basic job then yields 128 on all channels.
